tanimoto_and_cnt: RTL

- Stage directly downstream of the pre-stage popcount unit (cnt1).
- Consumes cnt1's sub-vector stream and its per-vector bit count.
- Stores one reference vector; for every later compare vector computes popcount(ref AND cmp).
- Emits the triple |ref|, |cmp|, |ref&cmp| to the Tanimoto divider stage.

---
 rtl/tanimoto_and_cnt.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/tanimoto_and_cnt.sv
// Stores a reference vector from the cnt1 sub-vector stream and, for every compare vector,
// pairs popcount(ref & cmp) with cnt1's per-vector counts for the Tanimoto divider.
module tanimoto_and_cnt #(
  parameter int unsigned BUS_WIDTH     = 128,
  parameter int unsigned SUB_VECTOR_NO = 2,
  parameter int unsigned CNT_WIDTH     = $clog2(BUS_WIDTH * SUB_VECTOR_NO) + 1,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [BUS_WIDTH-1:0] i_SubVector,
  input  logic                 i_Valid,
  input  logic                 i_LoadRef,
  input  logic [CNT_WIDTH-1:0] i_Cnt,
  input  logic                 i_CntValid,
  output logic [CNT_WIDTH-1:0] o_RefCnt,
  output logic [CNT_WIDTH-1:0] o_CmpCnt,
  output logic [CNT_WIDTH-1:0] o_AndCnt,
  output logic                 o_Valid,
  output logic                 o_RefLoaded,
  output logic                 o_Overflow
);

  localparam int unsigned K_W = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
  localparam int unsigned P_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(SUB_VECTOR_NO - 1);
  localparam logic [P_W:0] P_FULL = (P_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {NO_REF, LOADING, HAVE_REF} state_t;
  typedef enum logic [1:0] {TAG_REF, TAG_CMP, TAG_DROP} tag_t;

  function automatic logic [CNT_WIDTH-1:0] popcnt(input logic [BUS_WIDTH-1:0] v);
    logic [CNT_WIDTH-1:0] s;
    s = '0;
    for (int i = 0; i < BUS_WIDTH; i++) s = s + CNT_WIDTH'(v[i]);
    return s;
  endfunction

  state_t               state_q;
  logic [K_W-1:0]       k_q;
  logic                 type_q;
  tag_t                 vtag_q;
  logic [BUS_WIDTH-1:0] ref_q [SUB_VECTOR_NO];

  logic                 first_c, last_c, is_ref_c;
  tag_t                 tag_c;
  logic [CNT_WIDTH-1:0] and_pc_c;

  // Vector position/type decode; the tag is fixed by the state seen at the first sub-vector.
  always_comb begin
    first_c  = (k_q == '0);
    last_c   = (k_q == K_LAST);
    is_ref_c = first_c ? i_LoadRef : type_q;
    tag_c    = vtag_q;
    if (first_c) begin
      if (i_LoadRef)               tag_c = TAG_REF;
      else if (state_q == HAVE_REF) tag_c = TAG_CMP;
      else                          tag_c = TAG_DROP;
    end
    and_pc_c = popcnt(i_SubVector & ref_q[k_q]);
  end

  // Sub-vector counter, vector type, reference storage and load state machine.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= NO_REF;
      k_q         <= '0;
      type_q      <= 1'b0;
      vtag_q      <= TAG_REF;
      ref_q       <= '{default: '0};
      o_RefLoaded <= 1'b0;
    end else if (i_Valid) begin
      k_q <= last_c ? '0 : k_q + K_W'(1);
      if (first_c) begin
        type_q <= i_LoadRef;
        vtag_q <= tag_c;
      end
      if (is_ref_c) ref_q[k_q] <= i_SubVector;
      if (is_ref_c && last_c) begin
        state_q     <= HAVE_REF;
        o_RefLoaded <= 1'b1;
      end else if (first_c && i_LoadRef) begin
        state_q <= LOADING;
      end
    end
  end

  logic                 s1_valid, s1_first, s1_last;
  tag_t                 s1_tag;
  logic [CNT_WIDTH-1:0] s1_cnt;
  logic [CNT_WIDTH-1:0] acc_q;
  logic                 fin_valid;
  tag_t                 fin_tag;
  logic [CNT_WIDTH-1:0] fin_cnt;
  logic [CNT_WIDTH-1:0] sum_c;

  assign sum_c = (s1_first ? '0 : acc_q) + s1_cnt;

  // Stage 1 registers the per-sub-vector AND popcount, stage 2 accumulates and finalizes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s1_first  <= 1'b0;
      s1_last   <= 1'b0;
      s1_tag    <= TAG_REF;
      s1_cnt    <= '0;
      acc_q     <= '0;
      fin_valid <= 1'b0;
      fin_tag   <= TAG_REF;
      fin_cnt   <= '0;
    end else begin
      s1_valid  <= i_Valid;
      fin_valid <= s1_valid && s1_last;
      if (i_Valid) begin
        s1_first <= first_c;
        s1_last  <= last_c;
        s1_tag   <= tag_c;
        s1_cnt   <= and_pc_c;
      end
      if (s1_valid) begin
        acc_q   <= sum_c;
        fin_cnt <= sum_c;
        fin_tag <= s1_tag;
      end
    end
  end

  tag_t                 rq_tag [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0] rq_cnt [FIFO_DEPTH];
  logic [CNT_WIDTH-1:0] cq_cnt [FIFO_DEPTH];
  logic [P_W:0]         rq_wr, rq_rd, cq_wr, cq_rd;
  logic                 rq_full_c, cq_full_c, pop_c, rq_we_c, cq_we_c, ovf_c;

  // A full queue still accepts a push when the same cycle pops it.
  always_comb begin
    rq_full_c = ((rq_wr - rq_rd) == P_FULL);
    cq_full_c = ((cq_wr - cq_rd) == P_FULL);
    pop_c     = (rq_wr != rq_rd) && (cq_wr != cq_rd);
    rq_we_c   = fin_valid && (!rq_full_c || pop_c);
    cq_we_c   = i_CntValid && (!cq_full_c || pop_c);
    ovf_c     = (fin_valid && rq_full_c && !pop_c) || (i_CntValid && cq_full_c && !pop_c);
  end

  // Result/count queues and the paired pop that drives the registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rq_tag     <= '{default: TAG_REF};
      rq_cnt     <= '{default: '0};
      cq_cnt     <= '{default: '0};
      rq_wr      <= '0;
      rq_rd      <= '0;
      cq_wr      <= '0;
      cq_rd      <= '0;
      o_RefCnt   <= '0;
      o_CmpCnt   <= '0;
      o_AndCnt   <= '0;
      o_Valid    <= 1'b0;
      o_Overflow <= 1'b0;
    end else begin
      o_Valid <= 1'b0;
      if (rq_we_c) begin
        rq_tag[rq_wr[P_W-1:0]] <= fin_tag;
        rq_cnt[rq_wr[P_W-1:0]] <= fin_cnt;
        rq_wr                  <= rq_wr + (P_W + 1)'(1);
      end
      if (cq_we_c) begin
        cq_cnt[cq_wr[P_W-1:0]] <= i_Cnt;
        cq_wr                  <= cq_wr + (P_W + 1)'(1);
      end
      if (ovf_c) o_Overflow <= 1'b1;
      if (pop_c) begin
        rq_rd <= rq_rd + (P_W + 1)'(1);
        cq_rd <= cq_rd + (P_W + 1)'(1);
        case (rq_tag[rq_rd[P_W-1:0]])
          TAG_REF: o_RefCnt <= cq_cnt[cq_rd[P_W-1:0]];
          TAG_CMP: begin
            o_CmpCnt <= cq_cnt[cq_rd[P_W-1:0]];
            o_AndCnt <= rq_cnt[rq_rd[P_W-1:0]];
            o_Valid  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
